// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding, branch funct3 codes and PC step for the PC sequencer.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_RSP = 3'd2,
    EXEC     = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_sequencer_cond.sv
// rtl/pc_sequencer_cond.sv - combinational branch/jump resolution (module branch_cond).
module branch_cond
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    if (jump) begin
      taken = 1'b1;
    end else if (branch) begin
      // funct3 010/011 have no branch meaning and resolve as not taken
      case (funct3)
        F3_BEQ:  taken = zero;
        F3_BNE:  taken = ~zero;
        F3_BLT:  taken = $signed(a) < $signed(b);
        F3_BGE:  taken = $signed(a) >= $signed(b);
        F3_BLTU: taken = a < b;
        F3_BGEU: taken = a >= b;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute sequencer: FSM, program counter and retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  input  logic            exec_done,
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic            taken,
  output logic            misalign,
  output logic            halted,
  output logic [31:0]     instret
);

  state_t          state;
  state_t          state_next;
  logic            cond_taken;
  logic            retire;
  logic            bad_target;
  logic            halt_pend;
  logic [XLEN-1:0] next_pc;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .branch (branch),
    .jump   (jump),
    .zero   (zero),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .taken  (cond_taken)
  );

  assign taken      = (state == EXEC) && exec_done && cond_taken;
  assign bad_target = taken && (target[1:0] != 2'b00);
  assign retire     = (state == EXEC) && exec_done && !bad_target;
  assign next_pc    = taken ? target : pc + XLEN'(PC_STEP);
  assign imem_addr  = pc;

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rvalid) state_next = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          if (bad_target || halt_req || halt_pend) state_next = HALT;
          else state_next = FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= 32'd0;
      instret   <= 32'd0;
      misalign  <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_next;
      if (state == WAIT_RSP && imem_rvalid) instr <= imem_rdata;
      if (bad_target && state == EXEC) misalign <= 1'b1;
      if (retire) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
      // a halt request seen outside the retiring cycle is held until the next exec_done
      if (halt_req) halt_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam logic [63:0] RST = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, zero = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] a = '0, b = '0, target = '0;
  logic        halt_req = 1'b0;
  logic [63:0] pc;
  logic        taken, misalign, halted;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_pc;
  logic [31:0] exp_instret;
  logic        exp_halted, exp_mis, pend;

  pc_sequencer #(.XLEN(64), .RESET_PC(RST)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .exec_done(exec_done),
    .branch(branch), .jump(jump), .zero(zero), .funct3(funct3),
    .a(a), .b(b), .target(target), .halt_req(halt_req),
    .pc(pc), .taken(taken), .misalign(misalign), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic ref_taken(input logic br, input logic jp, input logic zr,
                                     input logic [2:0] f3, input logic [63:0] av, input logic [63:0] bv);
    if (jp) return 1'b1;
    if (!br) return 1'b0;
    case (f3)
      3'd0: return zr;
      3'd1: return !zr;
      3'd4: return $signed(av) < $signed(bv);
      3'd5: return $signed(av) >= $signed(bv);
      3'd6: return av < bv;
      3'd7: return av >= bv;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_exec_inputs();
    exec_done = 0; branch = 0; jump = 0; zero = 0; funct3 = 0;
    a = '0; b = '0; target = '0; halt_req = 0;
  endtask

  // reset pulse, then check the one IDLE cycle; leaves the DUT in FETCH
  task automatic do_reset();
    reset = 1; imem_gnt = 0; imem_rvalid = 0;
    clear_exec_inputs();
    step();
    reset = 0;
    exp_pc = RST; exp_instret = 0; exp_halted = 0; exp_mis = 0; pend = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_taken", taken, 0);
    chk("rst_pc", pc, RST);
    chk("rst_instr", instr, 0);
    chk("rst_instret", instret, 0);
    chk("rst_misalign", misalign, 0);
    step();
  endtask

  task automatic do_instr(input int gd, input int rd, input logic [31:0] word,
                          input logic br, input logic jp, input logic zr, input logic [2:0] f3,
                          input logic [63:0] av, input logic [63:0] bv, input logic [63:0] tg,
                          input logic hr);
    logic t;
    int hold;
    for (int i = 0; i <= gd; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, exp_pc);
      chk("fetch_ivalid", instr_valid, 0);
      imem_gnt = (i == gd);
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step();
    end
    imem_gnt = 0;
    imem_rvalid = 0;
    for (int i = 0; i <= rd; i++) begin
      chk("wait_req", imem_req, 0);
      chk("wait_ivalid", instr_valid, 0);
      imem_rvalid = (i == rd);
      imem_rdata = (i == rd) ? word : $urandom;
      step();
    end
    imem_rvalid = 0;
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      jump = 1; branch = 1;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      #1;
      chk("exec_ivalid", instr_valid, 1);
      chk("exec_instr_hold", instr, word);
      chk("taken_gated", taken, 0);
      step();
    end
    imem_rvalid = 0;
    branch = br; jump = jp; zero = zr; funct3 = f3; a = av; b = bv; target = tg;
    halt_req = hr; exec_done = 1;
    #1;
    t = ref_taken(br, jp, zr, f3, av, bv);
    chk("exec_ivalid", instr_valid, 1);
    chk("exec_instr", instr, word);
    chk("taken", taken, t);
    step();
    clear_exec_inputs();
    if (t && tg[1:0] != 2'b00) begin
      exp_mis = 1;
      exp_halted = 1;
    end else begin
      exp_pc = t ? tg : exp_pc + 64'd4;
      exp_instret = exp_instret + 32'd1;
      if (hr || pend) exp_halted = 1;
    end
    chk("pc", pc, exp_pc);
    chk("instret", instret, exp_instret);
    chk("misalign", misalign, exp_mis);
    chk("halted", halted, exp_halted);
    chk("next_req", imem_req, !exp_halted);
  endtask

  initial begin
    logic [63:0] av, bv, tg;
    do_reset();

    do_instr(0, 0, 32'h0000_0013, 0, 0, 0, 3'd0, '0, '0, 64'h3000, 0);
    chk("first_instret", instret, 1);
    do_instr(0, 0, 32'h0020_c463, 1, 0, 0, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2000, 0);
    chk("blt_pc", pc, 64'h2000);
    do_instr(0, 0, 32'h0020_e463, 1, 0, 0, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h2000, 0);
    chk("bltu_pc", pc, 64'h2004);
    do_instr(3, 2, 32'hCAFE_F00D, 0, 0, 0, 3'd0, '0, '0, '0, 0);

    for (int n = 0; n < 24; n++) begin
      av = {$urandom, $urandom};
      bv = ($urandom_range(0, 3) == 0) ? av : {$urandom, $urandom};
      tg = {$urandom, $urandom} & ~64'h3;
      do_instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom,
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), av, bv, tg, 0);
    end

    do_instr(0, 0, 32'h0000_006F, 0, 1, 0, 3'd0, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    do_instr(1, 1, 32'h0000_0013, 0, 0, 0, 3'd0, '0, '0, '0, 0);
    chk("pc_wrap", pc, 64'h0);

    imem_gnt = 1;
    step();
    imem_gnt = 0;
    chk("mid_wait_req", imem_req, 0);
    step();
    do_reset();
    chk("after_rst_req", imem_req, 1);
    do_reset();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    chk("late_fetch_req", imem_req, 1);
    step();
    chk("late_rvalid_ivalid", instr_valid, 0);
    chk("late_rvalid_instr", instr, 0);
    chk("late_rvalid_req", imem_req, 1);
    imem_rvalid = 0;
    do_instr(0, 0, 32'h1234_5678, 0, 0, 0, 3'd0, '0, '0, '0, 0);

    do_instr(0, 1, 32'h0000_0073, 0, 0, 0, 3'd0, '0, '0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      imem_gnt = 1; imem_rvalid = 1; exec_done = 1;
      step();
      chk("halt_absorb", halted, 1);
      chk("halt_req_low", imem_req, 0);
      chk("halt_pc", pc, exp_pc);
    end
    imem_gnt = 0; imem_rvalid = 0; exec_done = 0;

    do_reset();
    halt_req = 1;
    step();
    halt_req = 0;
    pend = 1;
    do_instr(0, 0, 32'h0000_0013, 0, 0, 0, 3'd0, '0, '0, '0, 0);
    chk("pend_halted", halted, 1);

    do_reset();
    do_instr(0, 0, 32'h0000_0013, 0, 0, 0, 3'd0, '0, '0, '0, 0);
    do_instr(0, 0, 32'h0000_006F, 0, 1, 0, 3'd0, '0, '0, 64'h2002, 0);
    chk("mis_pc", pc, RST + 64'd4);
    chk("mis_instret", instret, 1);
    step();
    step();
    chk("mis_sticky", misalign, 1);
    chk("mis_halted", halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter XLEN, default 64, meaning the PC and operand width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr, output, XLEN bits: fetch address, always equal to pc.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: request accepted this cycle.
REQ-008 The block SHALL have port imem_rvalid / imem_rdata, inputs, 1 / 32 bits: fetched instruction is returned.
REQ-009 The block SHALL have port instr_valid, output, 1 bit, and port instr, output, 32 bits: decoded-stage handoff.
REQ-010 The block SHALL have port exec_done, input, 1 bit: the datapath has finished the current instruction.
REQ-011 The block SHALL have ports branch, jump, zero (input, 1 bit each), funct3 (input, 3 bits), a and b (input, XLEN bits each), and target (input, XLEN bits): branch resolution inputs, sampled only when exec_done=1.
REQ-012 The block SHALL have port halt_req, input, 1 bit: stop the sequencer after the current instruction.
REQ-013 The block SHALL have port pc, output, XLEN bits: the current PC.
REQ-014 The block SHALL have ports taken (output, 1 bit), misalign (output, 1 bit), halted (output, 1 bit) and instret (output, 32 bits): status outputs.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WAIT_RSP, EXEC and HALT.
REQ-016 IDLE SHALL last exactly one cycle after reset deasserts, then go to FETCH.
REQ-017 FETCH SHALL hold imem_req=1 with a stable imem_addr until imem_gnt=1, then go to WAIT_RSP.
REQ-018 Any imem_rvalid seen in FETCH SHALL be ignored.
REQ-019 WAIT_RSP SHALL, on imem_rvalid=1, latch imem_rdata into instr and go to EXEC; imem_req SHALL be 0 outside FETCH.
REQ-020 instr_valid SHALL be 1 in every EXEC cycle and 0 otherwise; instr SHALL remain stable while in EXEC.
REQ-021 EXEC SHALL wait for exec_done=1; in that cycle taken SHALL be computed combinationally as follows: jump=1 -> 1; otherwise branch=0 -> 0; otherwise by funct3:
- 000 zero=1; 001 zero=0;
- 100 $signed(a)<$signed(b); 101 $signed(a)>=$signed(b);
- 110 a<b unsigned; 111 a>=b unsigned;
- 010/011 -> 0.
REQ-022 taken SHALL be 0 whenever exec_done=0 or the state is not EXEC.
REQ-023 On exec_done: next_pc SHALL be target if taken, else pc+4 modulo 2^XLEN (wraps silently); pc SHALL take that value on the following edge; instret SHALL increment by 1, wrapping at 2^32.
REQ-024 If taken=1 and target[1:0]!=0, the block SHALL leave pc unchanged, set misalign=1 (sticky), not increment instret, and go to HALT.
REQ-025 After a normal exec_done, the FSM SHALL go to HALT if halt_req=1 in that cycle, else to FETCH; halt_req in any other state SHALL take effect at the next exec_done.
REQ-026 HALT SHALL be absorbing until reset; halted=1 only in HALT.
REQ-027 Fetch latency SHALL be FETCH(>=1) + WAIT_RSP(>=1) cycles; with gnt and rvalid each asserted on their first opportunity, the handoff SHALL take 2 cycles and an instruction SHALL complete in 3 cycles minimum.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, pc=RESET_PC, instr=0, instret=0, misalign=0, imem_req=0, instr_valid=0, halted=0, taken=0.
REQ-029 Reset asserted in any state, including mid-handshake in FETCH or WAIT_RSP, SHALL abort the transaction; a late imem_rvalid arriving after reset SHALL be ignored, because the state is IDLE/FETCH.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the funct3 encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the constant PC_STEP=4.
REQ-031 Branch condition evaluation SHALL be a combinational sub-module, branch_cond (inputs branch, jump, zero, funct3, a, b; output taken); the FSM, PC and counter SHALL remain in pc_sequencer.

Verification
REQ-032 Reset with RESET_PC=0x1000, gnt and rvalid immediate -> imem_addr=0x1000 in the second cycle after reset, instr_valid in the fourth cycle.
REQ-033 Non-branch instruction, exec_done -> pc 0x1000 to 0x1004, instret=1, taken=0.
REQ-034 branch=1, funct3=100, a=-1, b=1, target=0x2000 -> taken=1, pc=0x2000; the same inputs with funct3=110 -> taken=0, pc+4.
REQ-035 imem_gnt delayed 3 cycles and rvalid delayed 2 cycles -> imem_req held for 4 cycles with a stable address, and instr is latched correctly.
REQ-036 jump=1, target=0x2002 -> misalign=1, halted=1, pc unchanged, instret unchanged.
REQ-037 pc=0xFFFF_FFFF_FFFF_FFFC, no branch -> pc=0; then reset asserted during WAIT_RSP -> IDLE, and the late rvalid is ignored.
